// File: rtl/polymul_seq.sv
// Sequential negacyclic polynomial multiplier: C = A*B mod (x^4+1), coefficients mod 2^CW.
// Optional macro POLYMUL_ZSKIP_EN skips rows whose A coefficient is zero.
module polymul_seq #(
  parameter int unsigned CW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4*CW-1:0] a,
  input  logic [4*CW-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4*CW-1:0] c,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state_q, state_d;
  logic [3:0]            k_q, k_d;
  logic [3:0][CW-1:0]    a_q, a_d, b_q, b_d, acc_q, acc_d;

  logic [1:0]            i, j, idx;
  logic                  wrap;
  logic [CW-1:0]         ai, bj, prod, acc_sel, acc_new;
  logic                  skip, last;

  // Shared datapath: one multiplier, one add/subtract.
  always_comb begin
    i           = k_q[3:2];
    j           = k_q[1:0];
    {wrap, idx} = {1'b0, i} + {1'b0, j};
    ai          = a_q[i];
    bj          = b_q[j];
    prod        = ai * bj;
    acc_sel     = acc_q[idx];
    acc_new     = wrap ? (acc_sel - prod) : (acc_sel + prod);
`ifdef POLYMUL_ZSKIP_EN
    skip        = (j == 2'd0) && (ai == '0);
`else
    skip        = 1'b0;
`endif
    // A skipped final row ends the computation just like step 15 would.
    last        = skip ? (i == 2'd3) : (k_q == 4'hF);
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          k_d     = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (skip) begin
          k_d = k_q + 4'd4;
        end else begin
          acc_d[idx] = acc_new;
          k_d        = k_q + 4'd1;
        end
        if (last) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign c         = acc_q;

endmodule
